// File: rtl/wshb_arb_pkg.sv
// wshb_arb_pkg: arbiter state encoding, default burst limit and counter width helper
package wshb_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} arb_state_e;
   localparam int unsigned MAX_ACKS_DEF = 64;
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/wshb_if.sv
// wshb_if: Wishbone B4 classic/registered-feedback bundle with master and slave views
interface wshb_if #(parameter int DW = 32, parameter int AW = 32);
   logic            cyc;
   logic            stb;
   logic            we;
   logic [AW-1:0]   adr;
   logic [DW-1:0]   dat_ms;
   logic [DW-1:0]   dat_sm;
   logic [DW/8-1:0] sel;
   logic [2:0]      cti;
   logic [1:0]      bte;
   logic            ack;
   logic            err;
   modport master (output cyc, stb, we, adr, dat_ms, sel, cti, bte, input dat_sm, ack, err);
   modport slave  (input cyc, stb, we, adr, dat_ms, sel, cti, bte, output dat_sm, ack, err);
endinterface

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: two-requester round-robin Wishbone arbiter; optional ack burst limit under WSHB_ARB_BURST_LIMIT_EN
module wshb_arbiter
   import wshb_arb_pkg::*;
#(
   parameter int unsigned MAX_ACKS = MAX_ACKS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   wshb_if.slave      wshb_ifs0,
   wshb_if.slave      wshb_ifs1,
   wshb_if.master     wshb_ifm,
   output logic [1:0] grant
);
   arb_state_e state_q, state_d;
   logic       ptr_q, ptr_d;
   logic       sel1, g0, g1, own_cyc, oth_cyc, lim_hit;

   assign sel1    = state_q == GNT1;
   assign g0      = !rst && state_q == GNT0;
   assign g1      = !rst && state_q == GNT1;
   assign own_cyc = sel1 ? wshb_ifs1.cyc : wshb_ifs0.cyc;
   assign oth_cyc = sel1 ? wshb_ifs0.cyc : wshb_ifs1.cyc;

   // next owner: idle picks by pointer, an owner leaves only on its own release or a burst-limit ack
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE) begin
         if (wshb_ifs0.cyc && (!wshb_ifs1.cyc || ptr_q))
            state_d = GNT0;
         else if (wshb_ifs1.cyc)
            state_d = GNT1;
      end else if (!own_cyc || (lim_hit && oth_cyc)) begin
         state_d = !oth_cyc ? IDLE : sel1 ? GNT0 : GNT1;
      end
      ptr_d = (state_d == GNT1) ? 1'b1 : (state_d == GNT0) ? 1'b0 : ptr_q;
   end

   // state and last-granted pointer; pointer starts at 1 so requester 0 wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef WSHB_ARB_BURST_LIMIT_EN
   localparam int unsigned    CW       = cnt_width(MAX_ACKS);
   localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_ACKS - 1);
   logic [CW-1:0] cnt_q, cnt_d;

   assign lim_hit = wshb_ifm.ack && state_q != IDLE && cnt_q == CNT_LAST;

   // owner ack count: restarts on every grant change and saturates at the limit
   always_comb begin
      cnt_d = (state_d != state_q) ? '0
            : (wshb_ifm.ack && state_q != IDLE && cnt_q != CNT_LAST) ? cnt_q + 1'b1
            : cnt_q;
   end

   // ack counter register
   always_ff @(posedge clk) begin
      cnt_q <= rst ? '0 : cnt_d;
   end
`else
   logic unused_max_acks;
   assign lim_hit         = 1'b0;
   assign unused_max_acks = |MAX_ACKS;
`endif

   assign grant           = {state_q == GNT1, state_q == GNT0};
   assign wshb_ifm.cyc    = g1 ? wshb_ifs1.cyc : g0 && wshb_ifs0.cyc;
   assign wshb_ifm.stb    = g1 ? wshb_ifs1.stb : g0 && wshb_ifs0.stb;
   assign wshb_ifm.we     = sel1 ? wshb_ifs1.we     : wshb_ifs0.we;
   assign wshb_ifm.adr    = sel1 ? wshb_ifs1.adr    : wshb_ifs0.adr;
   assign wshb_ifm.dat_ms = sel1 ? wshb_ifs1.dat_ms : wshb_ifs0.dat_ms;
   assign wshb_ifm.sel    = sel1 ? wshb_ifs1.sel    : wshb_ifs0.sel;
   assign wshb_ifm.cti    = sel1 ? wshb_ifs1.cti    : wshb_ifs0.cti;
   assign wshb_ifm.bte    = sel1 ? wshb_ifs1.bte    : wshb_ifs0.bte;
   assign wshb_ifs0.ack   = g0 && wshb_ifm.ack;
   assign wshb_ifs0.err   = g0 && wshb_ifm.err;
   assign wshb_ifs1.ack   = g1 && wshb_ifm.ack;
   assign wshb_ifs1.err   = g1 && wshb_ifm.err;
   assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
   assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;
endmodule

// File: tb/tb_wshb_arbiter.sv
// tb_wshb_arbiter: directed checks of grant, routing, reset and burst-limit behaviour
module tb_wshb_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] grant;
   int         n_chk = 0;
   int         n_fail = 0;
   int         acks0, acks1, cycles;

   wshb_if s0 ();
   wshb_if s1 ();
   wshb_if m ();

   wshb_arbiter #(.MAX_ACKS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .wshb_ifs0(s0),
      .wshb_ifs1(s1),
      .wshb_ifm (m),
      .grant    (grant)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      {s0.cyc, s0.stb, s0.we, s1.cyc, s1.stb, s1.we} = '0;
      s0.adr = '0; s0.dat_ms = '0; s0.sel = '1; s0.cti = '0; s0.bte = '0;
      s1.adr = '0; s1.dat_ms = '0; s1.sel = '1; s1.cti = '0; s1.bte = '0;
      m.ack = 1'b0; m.err = 1'b0; m.dat_sm = '0;
      // reset with a requester active and a stray slave ack
      s0.cyc = 1'b1; s0.stb = 1'b1; m.ack = 1'b1;
      tick(); tick();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_mcyc", 32'(m.cyc), 32'h0);
      chk("rst_mstb", 32'(m.stb), 32'h0);
      chk("rst_ack0", 32'(s0.ack), 32'h0);
      chk("rst_ack1", 32'(s1.ack), 32'h0);
      s0.cyc = 1'b0; s0.stb = 1'b0; m.ack = 1'b0; rst = 1'b0;
      tick();
      // single reader request, read at 0x10
      s1.cyc = 1'b1; s1.stb = 1'b1; s1.adr = 32'h10;
      #1;
      chk("lat_before", 32'(grant), 32'h0);
      tick();
      chk("lat_grant", 32'(grant), 32'h2);
      chk("rd_mcyc", 32'(m.cyc), 32'h1);
      chk("rd_madr", m.adr, 32'h10);
      m.dat_sm = 32'hCAFE0010; m.ack = 1'b1;
      #1;
      chk("rd_ack1", 32'(s1.ack), 32'h1);
      chk("rd_dat1", s1.dat_sm, 32'hCAFE0010);
      chk("rd_ack0", 32'(s0.ack), 32'h0);
      chk("rd_dat0", s0.dat_sm, 32'hCAFE0010);
      tick();
      m.ack = 1'b0; s1.cyc = 1'b0; s1.stb = 1'b0;
      tick();
      chk("rd_idle", 32'(grant), 32'h0);
      // simultaneous requests after reset
      rst = 1'b1; tick(); rst = 1'b0;
      s0.cyc = 1'b1; s0.stb = 1'b1; s0.adr = 32'h20;
      s1.cyc = 1'b1; s1.stb = 1'b1; s1.adr = 32'h30;
      tick();
      chk("tie_grant", 32'(grant), 32'h1);
      chk("tie_madr", m.adr, 32'h20);
      m.ack = 1'b1;
      #1;
      chk("tie_ack0", 32'(s0.ack), 32'h1);
      chk("tie_ack1", 32'(s1.ack), 32'h0);
      tick();
      m.ack = 1'b0; s0.cyc = 1'b0; s0.stb = 1'b0;
      tick();
      chk("tie_handover", 32'(grant), 32'h2);
      chk("tie_madr1", m.adr, 32'h30);
      s1.cyc = 1'b0; s1.stb = 1'b0;
      tick();
      chk("tie_idle", 32'(grant), 32'h0);
      // slave stall with a competing request
      s1.cyc = 1'b1; s1.stb = 1'b1;
      tick();
      s0.cyc = 1'b1; s0.stb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_grant", 32'(grant), 32'h2);
      end
      chk("stall_ack0", 32'(s0.ack), 32'h0);
      m.ack = 1'b1;
      #1;
      chk("stall_ack1", 32'(s1.ack), 32'h1);
      tick();
      m.ack = 1'b0;
      #1;
      chk("stall_hold", 32'(grant), 32'h2);
      s1.cyc = 1'b0; s1.stb = 1'b0;
      tick();
      chk("stall_next", 32'(grant), 32'h1);
      s0.cyc = 1'b0; s0.stb = 1'b0;
      tick();
      // reader streaming acks while writer waits
      s1.cyc = 1'b1; s1.stb = 1'b1;
      tick();
      chk("burst_start", 32'(grant), 32'h2);
      s0.cyc = 1'b1; s0.stb = 1'b1; m.ack = 1'b1;
      acks0 = 0; acks1 = 0; cycles = 0;
      for (int i = 0; i < 1000; i++) begin
         #0;
         acks0 += 32'(s0.ack);
         acks1 += 32'(s1.ack);
         tick();
         cycles++;
         if (grant != 2'b10) break;
      end
`ifdef WSHB_ARB_BURST_LIMIT_EN
      chk("burst_acks1", 32'(acks1), 32'd4);
      chk("burst_cycles", 32'(cycles), 32'd4);
      chk("burst_grant", 32'(grant), 32'h1);
      chk("burst_ack0", 32'(s0.ack), 32'h1);
      chk("burst_ack1", 32'(s1.ack), 32'h0);
      m.ack = 1'b0; s0.cyc = 1'b0; s0.stb = 1'b0;
      tick();
      chk("burst_back", 32'(grant), 32'h2);
      s1.cyc = 1'b0; s1.stb = 1'b0;
      tick();
`else
      chk("hold_acks1", 32'(acks1), 32'd1000);
      chk("hold_acks0", 32'(acks0), 32'd0);
      chk("hold_grant", 32'(grant), 32'h2);
      m.ack = 1'b0; s1.cyc = 1'b0; s1.stb = 1'b0;
      tick();
      chk("hold_release", 32'(grant), 32'h1);
      s0.cyc = 1'b0; s0.stb = 1'b0;
      tick();
`endif
      chk("pre_wr_idle", 32'(grant), 32'h0);
      // reset in the middle of a writer transaction
      s0.cyc = 1'b1; s0.stb = 1'b1; s0.we = 1'b1; s0.adr = 32'h40; s0.dat_ms = 32'hA5;
      tick();
      chk("wr_grant", 32'(grant), 32'h1);
      chk("wr_mwe", 32'(m.we), 32'h1);
      chk("wr_mdat", m.dat_ms, 32'hA5);
      rst = 1'b1;
      tick();
      chk("wr_rst_mcyc", 32'(m.cyc), 32'h0);
      chk("wr_rst_grant", 32'(grant), 32'h0);
      rst = 1'b0; s1.cyc = 1'b1; s1.stb = 1'b1;
      tick();
      chk("wr_rearb", 32'(grant), 32'h1);
      chk("wr_mcyc", 32'(m.cyc), 32'h1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
